// File: rtl/fragment_framebuffer_fetch_pkg.sv
// Shared definitions for the fragment framebuffer fetch stage.
// Holds default stream field widths and the width helper used to size
// the hazard scoreboard pointers and occupancy counter.
package fragment_framebuffer_fetch_pkg;

  localparam int FRAMEBUFFER_INDEX_WIDTH_DEF = 14;
  localparam int SCREEN_POS_WIDTH_DEF        = 16;
  localparam int DEPTH_WIDTH_DEF             = 16;
  localparam int STENCIL_WIDTH_DEF           = 4;
  localparam int PIXEL_WIDTH_DEF             = 32;
  localparam int HAZARD_DEPTH_DEF            = 8;

  // Source depth travels with the fragment unchanged and is always 32 bits.
  localparam int SRC_DEPTH_WIDTH = 32;

  // Number of bits needed to address 'depth' entries (ceil(log2(depth))).
  function automatic int ptr_width(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w = w + 1;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/fragment_hazard_scoreboard.sv
// In-flight framebuffer index scoreboard.
// A FIFO of {index, keep} entries: one entry is allocated per accepted
// fragment and the oldest entry is freed per write-back beat. A parallel
// compare against every occupied entry reports whether the queried index
// still has an outstanding write.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   alloc_i          push {index_i, keep_i} (ignored when full)
//   free_i           pop the oldest entry (ignored when empty)
//   index_i, keep_i  query index / keep of the candidate fragment, also the
//                    data pushed on alloc
//   hazard_o         candidate collides with an outstanding keep=1 entry
//   full_o           all entries occupied
//   count_o          number of occupied entries
//   head_index_o     index of the oldest entry (write-back ordering checks)
module fragment_hazard_scoreboard
  import fragment_framebuffer_fetch_pkg::*;
#(
  parameter int INDEX_WIDTH = FRAMEBUFFER_INDEX_WIDTH_DEF,
  parameter int DEPTH       = HAZARD_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc_i,
  input  logic                        free_i,
  input  logic [INDEX_WIDTH-1:0]      index_i,
  input  logic                        keep_i,
  output logic                        hazard_o,
  output logic                        full_o,
  output logic [ptr_width(DEPTH):0]   count_o,
  output logic [INDEX_WIDTH-1:0]      head_index_o
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INDEX_WIDTH-1:0] idx_q [DEPTH];
  logic [DEPTH-1:0]       keep_q, keep_d;
  logic [DEPTH-1:0]       vld_q, vld_d;
  logic [PTR_W-1:0]       wr_q, rd_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   do_alloc, do_free;

  assign full_o       = (cnt_q == CNT_W'(DEPTH));
  assign count_o      = cnt_q;
  assign head_index_o = idx_q[rd_q];
  assign do_alloc     = alloc_i && !full_o;
  assign do_free      = free_i && (cnt_q != '0);

  // Compare uses the entries as they stand this cycle; a same-cycle free
  // does not clear the hazard until the next cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    hazard_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && keep_q[i] && (idx_q[i] == index_i)) hazard_o = 1'b1;
    end
    hazard_o = hazard_o && keep_i;
  end

  always_comb begin
    vld_d  = vld_q;
    keep_d = keep_q;
    cnt_d  = cnt_q;
    if (do_free) vld_d[rd_q] = 1'b0;
    if (do_alloc) begin
      vld_d[wr_q]  = 1'b1;
      keep_d[wr_q] = keep_i;
    end
    if (do_alloc && !do_free)      cnt_d = cnt_q + CNT_W'(1);
    else if (!do_alloc && do_free) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      vld_q  <= '0;
      keep_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      keep_q <= keep_d;
      cnt_q  <= cnt_d;
      if (do_alloc) wr_q <= wr_q + PTR_W'(1);
      if (do_free)  rd_q <= rd_q + PTR_W'(1);
    end
  end

  // NOTE: the index storage is deliberately not reset; an entry is only
  // ever looked at while its valid bit (which is reset) is set.
  always_ff @(posedge clk) begin
    if (do_alloc) idx_q[wr_q] <= index_i;
  end

endmodule

// File: rtl/fragment_framebuffer_fetch.sv
// Fragment framebuffer fetch stage.
// Accepts textured fragments, reads destination color/depth/stencil from
// the tile buffers at the fragment's index and forwards the fragment with
// those values through a single output register. Fragments whose pixel
// still has an outstanding write-back are held at the input.
// Ports:
//   aclk, reset                  clock, asynchronous active-high reset
//   s_frag_*                     input fragment stream (valid/ready)
//   fb_ren, fb_raddr             tile buffer read request (1-cycle latency)
//   fb_*_rdata                   tile buffer read data, held while fb_ren=0
//   m_frag_*                     output fragment stream with destination data
//   wb_tvalid/tready/taddr       downstream write-back beat (frees oldest entry)
//   inFlight                     occupied scoreboard entries
//   idle                         no output pending and scoreboard empty
module fragment_framebuffer_fetch
  import fragment_framebuffer_fetch_pkg::*;
#(
  parameter int FRAMEBUFFER_INDEX_WIDTH = FRAMEBUFFER_INDEX_WIDTH_DEF,
  parameter int SCREEN_POS_WIDTH        = SCREEN_POS_WIDTH_DEF,
  parameter int DEPTH_WIDTH             = DEPTH_WIDTH_DEF,
  parameter int STENCIL_WIDTH           = STENCIL_WIDTH_DEF,
  parameter int PIXEL_WIDTH             = PIXEL_WIDTH_DEF,
  parameter int HAZARD_DEPTH            = HAZARD_DEPTH_DEF
) (
  input  logic                               aclk,
  input  logic                               reset,
  input  logic                               s_frag_tvalid,
  output logic                               s_frag_tready,
  input  logic                               s_frag_tlast,
  input  logic                               s_frag_tkeep,
  input  logic [PIXEL_WIDTH-1:0]             s_frag_tcolor,
  input  logic [SRC_DEPTH_WIDTH-1:0]         s_frag_tdepth,
  input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] s_frag_tindex,
  input  logic [SCREEN_POS_WIDTH-1:0]        s_frag_tscreenPosX,
  input  logic [SCREEN_POS_WIDTH-1:0]        s_frag_tscreenPosY,
  output logic                               fb_ren,
  output logic [FRAMEBUFFER_INDEX_WIDTH-1:0] fb_raddr,
  input  logic [PIXEL_WIDTH-1:0]             fb_color_rdata,
  input  logic [DEPTH_WIDTH-1:0]             fb_depth_rdata,
  input  logic [STENCIL_WIDTH-1:0]           fb_stencil_rdata,
  output logic                               m_frag_tvalid,
  input  logic                               m_frag_tready,
  output logic                               m_frag_tlast,
  output logic                               m_frag_tkeep,
  output logic [PIXEL_WIDTH-1:0]             m_frag_tcolor,
  output logic [SRC_DEPTH_WIDTH-1:0]         m_frag_tdepth,
  output logic [FRAMEBUFFER_INDEX_WIDTH-1:0] m_frag_tindex,
  output logic [SCREEN_POS_WIDTH-1:0]        m_frag_tscreenPosX,
  output logic [SCREEN_POS_WIDTH-1:0]        m_frag_tscreenPosY,
  output logic [PIXEL_WIDTH-1:0]             m_frag_tdestinationColor,
  output logic [DEPTH_WIDTH-1:0]             m_frag_tdestinationDepth,
  output logic [STENCIL_WIDTH-1:0]           m_frag_tdestinationStencil,
  input  logic                               wb_tvalid,
  input  logic                               wb_tready,
  input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] wb_taddr,
  output logic [ptr_width(HAZARD_DEPTH):0]   inFlight,
  output logic                               idle
);

  typedef struct packed {
    logic                               last;
    logic                               keep;
    logic [PIXEL_WIDTH-1:0]             color;
    logic [SRC_DEPTH_WIDTH-1:0]         depth;
    logic [FRAMEBUFFER_INDEX_WIDTH-1:0] index;
    logic [SCREEN_POS_WIDTH-1:0]        pos_x;
    logic [SCREEN_POS_WIDTH-1:0]        pos_y;
  } payload_t;

  logic                               valid_q, valid_d;
  payload_t                           payload_q, payload_d;
  logic                               accept, wb_fire;
  logic                               sb_hazard, sb_full;
  logic [ptr_width(HAZARD_DEPTH):0]   sb_count;
  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] sb_head_index;

  assign s_frag_tready = (!valid_q || m_frag_tready) && !sb_full && !sb_hazard;
  assign accept        = s_frag_tvalid && s_frag_tready;
  assign wb_fire       = wb_tvalid && wb_tready;

  // Reads are issued only on accept so the RAM output holds steady while
  // the output register is back-pressured.
  assign fb_ren   = accept;
  assign fb_raddr = s_frag_tindex;

  fragment_hazard_scoreboard #(
    .INDEX_WIDTH (FRAMEBUFFER_INDEX_WIDTH),
    .DEPTH       (HAZARD_DEPTH)
  ) u_scoreboard (
    .clk          (aclk),
    .rst          (reset),
    .alloc_i      (accept),
    .free_i       (wb_fire),
    .index_i      (s_frag_tindex),
    .keep_i       (s_frag_tkeep),
    .hazard_o     (sb_hazard),
    .full_o       (sb_full),
    .count_o      (sb_count),
    .head_index_o (sb_head_index)
  );

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (accept) begin
      valid_d   = 1'b1;
      payload_d = '{last:  s_frag_tlast,       keep:  s_frag_tkeep,
                    color: s_frag_tcolor,      depth: s_frag_tdepth,
                    index: s_frag_tindex,      pos_x: s_frag_tscreenPosX,
                    pos_y: s_frag_tscreenPosY};
    end else if (m_frag_tready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign m_frag_tvalid      = valid_q;
  assign m_frag_tlast       = payload_q.last;
  assign m_frag_tkeep       = payload_q.keep;
  assign m_frag_tcolor      = payload_q.color;
  assign m_frag_tdepth      = payload_q.depth;
  assign m_frag_tindex      = payload_q.index;
  assign m_frag_tscreenPosX = payload_q.pos_x;
  assign m_frag_tscreenPosY = payload_q.pos_y;

  // Destination data comes straight from the RAMs (their read latency
  // matches the output register); it is zeroed while no fragment is held.
  assign m_frag_tdestinationColor   = valid_q ? fb_color_rdata   : '0;
  assign m_frag_tdestinationDepth   = valid_q ? fb_depth_rdata   : '0;
  assign m_frag_tdestinationStencil = valid_q ? fb_stencil_rdata : '0;

  assign inFlight = sb_count;
  assign idle     = !valid_q && (sb_count == '0);

  // Write-back beats must retire fragments in acceptance order.
  wb_order_a: assert property (@(posedge aclk) disable iff (reset)
    wb_fire |-> ((sb_count != '0) && (wb_taddr == sb_head_index)));

endmodule
